// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with modulus limit, prescaler, one-shot halt and parallel load.
//   clock, clear_n (async active-low reset), clear (sync clear), enable, up, load, load_value,
//   limit (count range 0..limit), oneshot, prescale (step every prescale+1 enabled cycles)
//   -> Q (count), tick (step strobe), tc (terminal-count pulse), done (sticky one-shot halt flag)
module prog_counter #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 up,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  input  logic [WIDTH-1:0]     limit,
  input  logic                 oneshot,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]     Q,
  output logic                 tick,
  output logic                 tc,
  output logic                 done
);
  typedef enum logic {COUNT, HALT} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     q_q, q_d, nxt, term;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic                 tick_q, tick_d, tc_q, tc_d, done_q, done_d, step;
  always_comb begin
    q_d     = q_q;
    pre_d   = pre_q;
    state_d = state_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    done_d  = done_q;
    step    = enable && (pre_q >= prescale);
    term    = up ? limit : '0;
    // >= against limit keeps a shrunk limit or an out-of-range load from running past the bound
    nxt     = up ? ((q_q >= limit) ? (oneshot ? limit : '0) : q_q + WIDTH'(1))
                 : ((q_q == '0) ? (oneshot ? '0 : limit) : q_q - WIDTH'(1));
    if (clear) begin
      q_d     = '0;
      pre_d   = '0;
      state_d = COUNT;
      done_d  = 1'b0;
    end else if (load) begin
      q_d     = load_value;
      pre_d   = '0;
      state_d = COUNT;
      done_d  = 1'b0;
    end else begin
      if (enable) begin
        pre_d  = step ? '0 : pre_q + PRE_WIDTH'(1);
        tick_d = step;
      end
      // halted: steps are swallowed; leaving one-shot mode resumes counting on the following step
      if (state_q == HALT) begin
        if (!oneshot) begin
          state_d = COUNT;
          done_d  = 1'b0;
        end
      end else if (step) begin
        q_d = nxt;
        if (!oneshot) tc_d = up ? (q_q >= limit) : (q_q == '0);
        else if (nxt == term) begin
          tc_d    = 1'b1;
          done_d  = 1'b1;
          state_d = HALT;
        end
      end
    end
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      q_q     <= '0;
      pre_q   <= '0;
      state_q <= COUNT;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      pre_q   <= pre_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end
  assign Q    = q_q;
  assign tick = tick_q;
  assign tc   = tc_q;
  assign done = done_q;
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: randomized and directed checks of prog_counter against a behavioural model.
module tb_prog_counter;
  logic       clock = 1'b0, clear_n = 1'b0, clear = 1'b0, enable = 1'b0, up = 1'b1;
  logic       load = 1'b0, oneshot = 1'b0;
  logic [7:0] load_value = 8'd0, limit = 8'd9, prescale = 8'd0;
  logic [7:0] Q;
  logic       tick, tc, done;
  int         errors = 0, checks = 0;
  int         m_q, m_pre;
  bit         m_halt, m_done, m_tick, m_tc;

  prog_counter #(.WIDTH(8), .PRE_WIDTH(8)) dut (
    .clock(clock), .clear_n(clear_n), .clear(clear), .enable(enable), .up(up),
    .load(load), .load_value(load_value), .limit(limit), .oneshot(oneshot),
    .prescale(prescale), .Q(Q), .tick(tick), .tc(tc), .done(done)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_q = 0; m_pre = 0; m_halt = 0; m_done = 0; m_tick = 0; m_tc = 0;
  endtask

  // Behavioural view: count lives in 0..limit, terminal is the end you're heading toward.
  task automatic model_edge();
    int lim, target;
    bit fire;
    lim = int'(limit);
    m_tick = 0; m_tc = 0; fire = 0;
    if (clear) begin
      m_q = 0; m_pre = 0; m_halt = 0; m_done = 0;
    end else if (load) begin
      m_q = int'(load_value); m_pre = 0; m_halt = 0; m_done = 0;
    end else begin
      if (enable) begin
        fire = (m_pre >= int'(prescale));
        m_pre = fire ? 0 : m_pre + 1;
        m_tick = fire;
      end
      if (m_halt) begin
        if (!oneshot) begin m_halt = 0; m_done = 0; end
      end else if (fire) begin
        if (!oneshot) begin
          if (up) begin m_tc = (m_q >= lim); m_q = m_tc ? 0 : m_q + 1; end
          else begin m_tc = (m_q == 0); m_q = m_tc ? lim : m_q - 1; end
        end else begin
          target = up ? lim : 0;
          if (up) m_q = (m_q >= lim) ? lim : m_q + 1;
          else m_q = (m_q == 0) ? 0 : m_q - 1;
          if (m_q == target) begin m_tc = 1; m_done = 1; m_halt = 1; end
        end
      end
    end
    m_q = m_q % 256;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({Q, tick, tc, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset: Q=%0d tick=%b tc=%b done=%b, expected all zero", Q, tick, tc, done);
    end
    @(negedge clock);
    clear_n = 1'b1;
    model_reset();
  endtask

  task automatic test_async_reset();
    limit = 8'd9; up = 1'b1; prescale = 8'd0; oneshot = 1'b0; enable = 1'b0; clear = 1'b1;
    cycle();
    clear = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      checks++;
      if ({Q, tick, tc, done} !== {m_q[7:0], m_tick, m_tc, m_done} || int'(Q) != i) begin
        errors++;
        $display("FAIL async_count %0d: Q=%0d tick=%b tc=%b done=%b, expected Q=%0d tick=%b tc=%b done=%b",
                 i, Q, tick, tc, done, i, m_tick, m_tc, m_done);
      end
    end
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if ({Q, tc, done, tick} !== 11'd0) begin
      errors++;
      $display("FAIL async_clear: Q=%0d tc=%b done=%b tick=%b, expected all zero", Q, tc, done, tick);
    end
    model_reset();
    #1 clear_n = 1'b1;
    cycle();
    checks++;
    if (Q !== 8'd1 || {Q, tick, tc, done} !== {m_q[7:0], m_tick, m_tc, m_done}) begin
      errors++;
      $display("FAIL async_resume: Q=%0d tick=%b, expected Q=1 tick=%b", Q, tick, m_tick);
    end
  endtask

  task automatic test_up_wrap();
    clear = 1'b1; up = 1'b1; limit = 8'd9; enable = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if ({Q, tick, tc, done} !== {m_q[7:0], m_tick, m_tc, m_done} || int'(Q) != i % 10 || tc !== (i == 10)) begin
        errors++;
        $display("FAIL up_wrap %0d: Q=%0d tc=%b, expected Q=%0d tc=%b", i, Q, tc, i % 10, i == 10);
      end
    end
  endtask

  task automatic test_down_wrap();
    int exp_q[3] = '{1, 0, 9};
    load_value = 8'd2; load = 1'b1;
    cycle();
    load = 1'b0; up = 1'b0;
    checks++;
    if (Q !== 8'd2) begin
      errors++;
      $display("FAIL down_load: Q=%0d, expected Q=2", Q);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({Q, tick, tc, done} !== {m_q[7:0], m_tick, m_tc, m_done} || int'(Q) != exp_q[i] || tc !== (i == 2)) begin
        errors++;
        $display("FAIL down_wrap %0d: Q=%0d tc=%b, expected Q=%0d tc=%b", i, Q, tc, exp_q[i], i == 2);
      end
    end
  endtask

  task automatic test_prescaler();
    up = 1'b1; clear = 1'b1; prescale = 8'd3;
    cycle();
    clear = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      enable = (i <= 10 || i > 15);
      cycle();
      checks++;
      if ({Q, tick, tc, done} !== {m_q[7:0], m_tick, m_tc, m_done} ||
          (i <= 8 && (int'(Q) != i / 4 || tick !== (i % 4 == 0))) ||
          (i == 17 && (Q !== 8'd3 || tick !== 1'b1))) begin
        errors++;
        $display("FAIL prescale %0d: Q=%0d tick=%b, expected Q=%0d tick=%b", i, Q, tick, m_q, m_tick);
      end
    end
  endtask

  task automatic test_oneshot();
    enable = 1'b1; prescale = 8'd0; limit = 8'd5; oneshot = 1'b1; up = 1'b1; clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      load = (i == 10); load_value = 8'd2;
      oneshot = (i < 14);
      cycle();
      checks++;
      if ({Q, tick, tc, done} !== {m_q[7:0], m_tick, m_tc, m_done} ||
          (i == 5 && {Q, tc, done} !== {8'd5, 1'b1, 1'b1}) ||
          (i == 9 && {Q, tc, done} !== {8'd5, 1'b0, 1'b1}) ||
          (i == 10 && {Q, done} !== {8'd2, 1'b0}) ||
          (i == 14 && {Q, done} !== {8'd5, 1'b0}) ||
          (i == 15 && {Q, tc} !== {8'd0, 1'b1})) begin
        errors++;
        $display("FAIL oneshot %0d: Q=%0d tick=%b tc=%b done=%b, expected Q=%0d tick=%b tc=%b done=%b",
                 i, Q, tick, tc, done, m_q, m_tick, m_tc, m_done);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_priority();
    oneshot = 1'b0; limit = 8'd9; up = 1'b1; enable = 1'b1; prescale = 8'd0;
    clear = 1'b1; load = 1'b1; load_value = 8'd7;
    cycle();
    checks++;
    if (Q !== 8'd0 || Q !== m_q[7:0]) begin
      errors++;
      $display("FAIL clear_over_load: Q=%0d, expected Q=0", Q);
    end
    clear = 1'b0; load = 1'b0;
    cycle();
    load = 1'b1; load_value = 8'd6;
    cycle();
    checks++;
    if ({Q, tick} !== {8'd6, 1'b0} || Q !== m_q[7:0]) begin
      errors++;
      $display("FAIL load_over_step: Q=%0d tick=%b, expected Q=6 tick=0", Q, tick);
    end
    load_value = 8'd12;
    cycle();
    load = 1'b0;
    cycle();
    checks++;
    if ({Q, tc} !== {8'd0, 1'b1} || {Q, tick, tc, done} !== {m_q[7:0], m_tick, m_tc, m_done}) begin
      errors++;
      $display("FAIL out_of_range_load: Q=%0d tc=%b, expected Q=0 tc=1", Q, tc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clear      = ($urandom % 40) == 0;
      load       = ($urandom % 25) == 0;
      enable     = ($urandom % 4) != 0;
      up         = ($urandom % 3) != 0;
      oneshot    = ($urandom % 5) < 2;
      load_value = 8'($urandom % 16);
      if ($urandom % 30 == 0) limit = 8'($urandom % 12);
      if ($urandom % 30 == 0) prescale = 8'($urandom % 3);
      cycle();
      checks++;
      if ({Q, tick, tc, done} !== {m_q[7:0], m_tick, m_tc, m_done}) begin
        errors++;
        $display("FAIL random %0d: Q=%0d tick=%b tc=%b done=%b, expected Q=%0d tick=%b tc=%b done=%b",
                 i, Q, tick, tc, done, m_q, m_tick, m_tc, m_done);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_async_reset();
    test_up_wrap();
    test_down_wrap();
    test_prescaler();
    test_oneshot();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
